// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board controller and display path:
// cell encodings, controller states, gameover bit positions and the table of
// cell indices that make up each of the eight winning lines.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    GC_IDLE  = 2'd0,
    GC_CHECK = 2'd1,
    GC_CLEAR = 2'd2
  } gc_state_t;

  // gameover = {over, x_won, line_mask[7:0]}
  localparam int GO_OVER_BIT = 9;
  localparam int GO_XWIN_BIT = 8;

  // Rows 0..2, columns 0..2, main diagonal, anti-diagonal.
  localparam logic [3:0] LINE_CELLS [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Reads one 2-bit cell out of the packed board; indices past the board read empty.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] v;
    v = CELL_EMPTY;
    if (idx < 4'(NUM_CELLS)) v = b[{idx, 1'b0} +: 2];
    return v;
  endfunction

endpackage

// File: rtl/ttt_line_lut.sv
// Maps a line number (0..7) to the three board cells forming that line.
// Purely combinational; also used by the display driver to highlight wins.
module ttt_line_lut
  import ttt_pkg::*;
(
  input  logic [2:0] line_i,
  output logic [3:0] c0_o,
  output logic [3:0] c1_o,
  output logic [3:0] c2_o
);

  assign c0_o = LINE_CELLS[line_i][0];
  assign c1_o = LINE_CELLS[line_i][1];
  assign c2_o = LINE_CELLS[line_i][2];

endmodule

// File: rtl/game_ctrl.sv
// Tic-tac-toe board owner. Accepts single-cycle move requests, writes legal
// moves, then walks the eight lines one per cycle to build the gameover
// vector. A request after game over clears the board one cell per cycle.
module game_ctrl
  import ttt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic [1:0]  wd,
  input  logic        wen,
  output logic [1:0]  ud,
  output logic [9:0]  gameover,
  output logic [17:0] board,
  output logic        busy
);

  gc_state_t   state_q, state_d;
  logic [2:0]  line_q, line_d;
  logic [3:0]  cell_q, cell_d;
  logic [7:0]  mask_q, mask_d;
  logic [1:0]  mover_q, mover_d;
  logic [17:0] board_q, board_d;
  logic [9:0]  go_q, go_d;
  logic [1:0]  ud_q, ud_d;

  logic [1:0]  row, col;
  logic [3:0]  tgt_idx;
  logic        coords_ok;
  logic        move_ok;
  logic [3:0]  lc0, lc1, lc2;
  logic        line_hit;
  logic [7:0]  mask_fin;
  logic        board_full;

  assign row       = addr[3:2];
  assign col       = addr[1:0];
  assign tgt_idx   = {2'b00, row} * 4'd3 + {2'b00, col};
  assign coords_ok = (row <= 2'd2) && (col <= 2'd2);
  assign move_ok   = coords_ok
                     && (cell_at(board_q, tgt_idx) == CELL_EMPTY)
                     && ((wd == CELL_X) || (wd == CELL_O));

  ttt_line_lut u_lut (
    .line_i (line_q),
    .c0_o   (lc0),
    .c1_o   (lc1),
    .c2_o   (lc2)
  );

  // Line under evaluation this cycle is complete for the current mover.
  assign line_hit = (cell_at(board_q, lc0) == mover_q)
                 && (cell_at(board_q, lc1) == mover_q)
                 && (cell_at(board_q, lc2) == mover_q);

  // Accumulated mask including the current line, plus board-full detection for draws.
  always_comb begin
    mask_fin = mask_q;
    mask_fin[line_q] = line_hit;
    board_full = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (board_q[2*i +: 2] == CELL_EMPTY) board_full = 1'b0;
    end
  end

  // Readback of the addressed cell; out-of-range coordinates read empty.
  always_comb begin
    ud_d = CELL_EMPTY;
    if (coords_ok) ud_d = cell_at(board_q, tgt_idx);
  end

  // Controller next-state: accept moves, scan lines, clear the board.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cell_d  = cell_q;
    mask_d  = mask_q;
    mover_d = mover_q;
    board_d = board_q;
    go_d    = go_q;
    case (state_q)
      GC_IDLE: begin
        if (wen) begin
          if (go_q[GO_OVER_BIT]) begin
            // Any request after game over is a restart; addr/wd are ignored.
            state_d = GC_CLEAR;
            cell_d  = 4'd0;
          end else if (move_ok) begin
            board_d[{tgt_idx, 1'b0} +: 2] = wd;
            mover_d = wd;
            line_d  = 3'd0;
            mask_d  = 8'h00;
            state_d = GC_CHECK;
          end
        end
      end
      GC_CHECK: begin
        mask_d = mask_fin;
        line_d = line_q + 3'd1;
        if (line_q == 3'd7) begin
          // gameover changes only here, after the last line, in one step.
          state_d = GC_IDLE;
          line_d  = 3'd0;
          if (mask_fin != 8'h00) begin
            go_d = {1'b1, mover_q == CELL_X, mask_fin};
          end else if (board_full) begin
            go_d = {1'b1, 1'b0, 8'h00};
          end else begin
            go_d = 10'd0;
          end
        end
      end
      GC_CLEAR: begin
        board_d[{cell_q, 1'b0} +: 2] = CELL_EMPTY;
        cell_d = cell_q + 4'd1;
        if (cell_q == 4'd8) begin
          state_d = GC_IDLE;
          cell_d  = 4'd0;
          go_d    = 10'd0;
        end
      end
      default: begin
        state_d = GC_IDLE;
      end
    endcase
  end

  // State and board registers; reset aborts any scan or clear in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GC_IDLE;
      line_q  <= 3'd0;
      cell_q  <= 4'd0;
      mask_q  <= 8'h00;
      mover_q <= CELL_EMPTY;
      board_q <= 18'd0;
      go_q    <= 10'd0;
      ud_q    <= CELL_EMPTY;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cell_q  <= cell_d;
      mask_q  <= mask_d;
      mover_q <= mover_d;
      board_q <= board_d;
      go_q    <= go_d;
      ud_q    <= ud_d;
    end
  end

  assign ud       = ud_q;
  assign gameover = go_q;
  assign board    = board_q;
  assign busy     = (state_q != GC_IDLE);

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl: directed scenarios followed by random games,
// all checked against a rule-level model of the board and game outcome.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr;
  logic [1:0]  wd;
  logic        wen;
  logic [1:0]  ud;
  logic [9:0]  gameover;
  logic [17:0] board;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  int         cells [9];
  logic [9:0] go_m;

  game_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wd       (wd),
    .wen      (wen),
    .ud       (ud),
    .gameover (gameover),
    .board    (board),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] pack_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(cells[i]);
    return b;
  endfunction

  // Outcome after a move by 'mover', from the rules of tic-tac-toe.
  function automatic logic [9:0] ref_go(input int mover);
    logic [7:0] mask;
    int a, b, c;
    bit full;
    mask = '0;
    for (int l = 0; l < 8; l++) begin
      if (l < 3)       begin a = l*3; b = a + 1; c = a + 2; end
      else if (l < 6)  begin a = l - 3; b = a + 3; c = a + 6; end
      else if (l == 6) begin a = 0; b = 4; c = 8; end
      else             begin a = 2; b = 4; c = 6; end
      if (cells[a] == mover && cells[b] == mover && cells[c] == mover) mask[l] = 1'b1;
    end
    full = 1'b1;
    for (int i = 0; i < 9; i++) if (cells[i] == 0) full = 1'b0;
    if (mask != 0) return {1'b1, mover == 1, mask};
    if (full) return 10'b10_0000_0000;
    return 10'd0;
  endfunction

  function automatic logic [3:0] cell_addr(input int idx);
    return {2'(idx / 3), 2'(idx % 3)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] a, input logic [1:0] w);
    addr = a;
    wd   = w;
    wen  = 1'b1;
    tick();
    wen  = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9; i++) cells[i] = 0;
    go_m = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wen = 1'b0;
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = 1'b0; addr = 4'd0; wd = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    n_cmp++; if (board !== 18'd0) begin n_bad++; $display("FAIL reset_board: got %h want 0", board); end
    n_cmp++; if (gameover !== 10'd0) begin n_bad++; $display("FAIL reset_gameover: got %h want 0", gameover); end
    n_cmp++; if (ud !== 2'd0) begin n_bad++; $display("FAIL reset_ud: got %h want 0", ud); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_first_move();
    int n;
    pulse(4'b0101, 2'b01);
    cells[4] = 1;
    n_cmp++; if (board[9:8] !== 2'b01) begin n_bad++; $display("FAIL first_cell: got %b want 01", board[9:8]); end
    n_cmp++; if (ud !== 2'b00) begin n_bad++; $display("FAIL first_ud_premove: got %b want 00", ud); end
    wait_idle(n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL first_busy_len: got %0d want 8", n); end
    go_m = ref_go(1);
    n_cmp++; if (gameover !== go_m) begin n_bad++; $display("FAIL first_gameover: got %h want %h", gameover, go_m); end
    tick();
    n_cmp++; if (ud !== 2'b01) begin n_bad++; $display("FAIL first_ud_readback: got %b want 01", ud); end
  endtask

  task automatic test_illegal();
    logic [3:0] ia [4] = '{4'b0101, 4'b0011, 4'b0000, 4'b1100};
    logic [1:0] iw [4] = '{2'b10,   2'b01,   2'b00,   2'b11};
    logic [1:0] exp_ud;
    for (int k = 0; k < 4; k++) begin
      exp_ud = (ia[k][3:2] <= 2 && ia[k][1:0] <= 2) ? 2'(cells[ia[k][3:2]*3 + ia[k][1:0]]) : 2'b00;
      pulse(ia[k], iw[k]);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL illegal_busy[%0d]: got %b want 0", k, busy); end
      n_cmp++; if (board !== pack_board()) begin n_bad++; $display("FAIL illegal_board[%0d]: got %h want %h", k, board, pack_board()); end
      n_cmp++; if (ud !== exp_ud) begin n_bad++; $display("FAIL illegal_ud[%0d]: got %b want %b", k, ud, exp_ud); end
    end
  endtask

  task automatic test_x_diag();
    int mc [5] = '{0, 1, 4, 2, 8};
    int mw [5] = '{1, 2, 1, 2, 1};
    logic [9:0] prev;
    do_reset();
    for (int m = 0; m < 5; m++) begin
      prev = gameover;
      cells[mc[m]] = mw[m];
      pulse(cell_addr(mc[m]), 2'(mw[m]));
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (busy !== 1'b1 || gameover !== prev) begin
          n_bad++; $display("FAIL diag_check_hold[%0d,%0d]: busy %b go %h want busy 1 go %h", m, k, busy, gameover, prev);
        end
        tick();
      end
      go_m = ref_go(mw[m]);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL diag_busy_end[%0d]: got %b want 0", m, busy); end
      n_cmp++; if (gameover !== go_m) begin n_bad++; $display("FAIL diag_gameover[%0d]: got %h want %h", m, gameover, go_m); end
    end
    n_cmp++; if (gameover !== 10'b11_0100_0000) begin n_bad++; $display("FAIL diag_final: got %b want 1101000000", gameover); end
  endtask

  task automatic test_draw();
    int mc [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int mw [9] = '{1, 2, 1, 2, 1, 2, 1, 2, 1};
    int n;
    do_reset();
    for (int m = 0; m < 9; m++) begin
      cells[mc[m]] = mw[m];
      pulse(cell_addr(mc[m]), 2'(mw[m]));
      wait_idle(n);
      go_m = ref_go(mw[m]);
      n_cmp++; if (gameover !== go_m) begin n_bad++; $display("FAIL draw_gameover[%0d]: got %h want %h", m, gameover, go_m); end
    end
    n_cmp++; if (gameover !== 10'b10_0000_0000) begin n_bad++; $display("FAIL draw_final: got %b want 1000000000", gameover); end
    n_cmp++; if (board !== pack_board()) begin n_bad++; $display("FAIL draw_board: got %h want %h", board, pack_board()); end
  endtask

  task automatic test_restart();
    logic [9:0] old;
    int n;
    old = gameover;
    pulse(4'(($urandom)), 2'($urandom));
    n_cmp++; if (busy !== 1'b1 || board !== pack_board()) begin n_bad++; $display("FAIL restart_start: busy %b board %h want busy 1 board %h", busy, board, pack_board()); end
    for (int j = 0; j < 9; j++) begin
      tick();
      cells[j] = 0;
      n_cmp++; if (board !== pack_board()) begin n_bad++; $display("FAIL restart_board[%0d]: got %h want %h", j, board, pack_board()); end
      if (j < 8) begin
        n_cmp++; if (busy !== 1'b1 || gameover !== old) begin n_bad++; $display("FAIL restart_hold[%0d]: busy %b go %h want busy 1 go %h", j, busy, gameover, old); end
      end else begin
        n_cmp++; if (busy !== 1'b0 || gameover !== 10'd0) begin n_bad++; $display("FAIL restart_end: busy %b go %h want busy 0 go 0", busy, gameover); end
      end
    end
    go_m = '0;
    cells[0] = 2;
    pulse(4'b0000, 2'b10);
    n_cmp++; if (board !== pack_board() || busy !== 1'b1) begin n_bad++; $display("FAIL restart_next_move: board %h busy %b want board %h busy 1", board, busy, pack_board()); end
    wait_idle(n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL restart_next_busy: got %0d want 8", n); end
  endtask

  task automatic test_reset_mid_check();
    int n;
    do_reset();
    pulse(4'b0110, 2'b10);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    n_cmp++; if (board !== 18'd0 || gameover !== 10'd0 || ud !== 2'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_outputs: board %h go %h ud %b busy %b want all 0", board, gameover, ud, busy);
    end
    cells[0] = 1;
    pulse(4'b0000, 2'b01);
    wait_idle(n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL midreset_idle_after: busy len %0d want 8", n); end
  endtask

  task automatic test_busy_wen();
    int n;
    cells[4] = 2;
    pulse(4'b0101, 2'b10);
    tick(); tick();
    pulse(4'b1010, 2'b01);
    wait_idle(n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL busywen_len: got %0d want 5", n); end
    n_cmp++; if (board !== pack_board()) begin n_bad++; $display("FAIL busywen_board: got %h want %h", board, pack_board()); end
    go_m = ref_go(2);
    n_cmp++; if (gameover !== go_m) begin n_bad++; $display("FAIL busywen_gameover: got %h want %h", gameover, go_m); end
  endtask

  task automatic test_random();
    int r, c, w, idx;
    logic [9:0] prev;
    logic [1:0] exp_ud;
    do_reset();
    for (int it = 0; it < 120; it++) begin
      r = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      c = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      w = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 3) : $urandom_range(1, 2);
      idx = r*3 + c;
      if (go_m[9]) begin
        pulse({2'(r), 2'(c)}, 2'(w));
        for (int j = 0; j < 9; j++) tick();
        model_clear();
        n_cmp++; if (board !== 18'd0 || busy !== 1'b0 || gameover !== 10'd0) begin
          n_bad++; $display("FAIL rand_restart[%0d]: board %h busy %b go %h want 0 0 0", it, board, busy, gameover);
        end
      end else if (r <= 2 && c <= 2 && (w == 1 || w == 2) && cells[idx] == 0) begin
        prev = gameover;
        cells[idx] = w;
        pulse({2'(r), 2'(c)}, 2'(w));
        n_cmp++; if (board !== pack_board() || ud !== 2'b00) begin
          n_bad++; $display("FAIL rand_write[%0d]: board %h ud %b want board %h ud 00", it, board, ud, pack_board());
        end
        for (int k = 0; k < 8; k++) begin
          n_cmp++; if (busy !== 1'b1 || gameover !== prev) begin
            n_bad++; $display("FAIL rand_check_hold[%0d,%0d]: busy %b go %h want busy 1 go %h", it, k, busy, gameover, prev);
          end
          tick();
        end
        go_m = ref_go(w);
        n_cmp++; if (busy !== 1'b0 || gameover !== go_m) begin
          n_bad++; $display("FAIL rand_gameover[%0d]: busy %b go %h want busy 0 go %h", it, busy, gameover, go_m);
        end
      end else begin
        exp_ud = (r <= 2 && c <= 2) ? 2'(cells[idx]) : 2'b00;
        pulse({2'(r), 2'(c)}, 2'(w));
        n_cmp++; if (busy !== 1'b0 || board !== pack_board() || ud !== exp_ud) begin
          n_bad++; $display("FAIL rand_drop[%0d]: busy %b board %h ud %b want busy 0 board %h ud %b", it, busy, board, ud, pack_board(), exp_ud);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; addr = 4'd0; wd = 2'd0;
    model_clear();
    test_reset();
    test_first_move();
    test_illegal();
    test_x_diag();
    test_draw();
    test_restart();
    test_reset_mid_check();
    test_busy_wen();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
